// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/data/grant bundle shared between the requesters
// (master side) and the bus arbiter (slave side).
interface bus_arbiter_if #(
   parameter int CHANNELS = 4,
   parameter int BUS_SIZE = 32
);
   logic [CHANNELS-1:0]          req;
   logic [CHANNELS*BUS_SIZE-1:0] data_in;
   logic [CHANNELS-1:0]          grant;
   logic [CHANNELS-1:0]          selector;
   logic [BUS_SIZE-1:0]          data_out;
   logic                         data_valid;
   logic                         busy;
   logic                         timeout;

   modport master (
      output req, data_in,
      input  grant, selector, data_out, data_valid, busy, timeout
   );

   modport slave (
      input  req, data_in,
      output grant, selector, data_out, data_valid, busy, timeout
   );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for CHANNELS requesters sharing one bus.
// IDLE -> GRANT -> RELEASE -> IDLE; the search starts after the last holder.
// Optional feature: define ARBITER_TIMEOUT_EN to force release of a holder
// after MAX_HOLD consecutive GRANT cycles (timeout pulses during RELEASE).
module bus_arbiter #(
   parameter int CHANNELS = 4,
   parameter int BUS_SIZE = 32,
   parameter int MAX_HOLD = 16
) (
   input logic          clk,
   input logic          reset_n,
   bus_arbiter_if.slave bus
);
   localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CHANNELS-1:0] grant_q, grant_d;
   logic [IW-1:0]       sel_q, sel_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [BUS_SIZE-1:0] data_out_q, data_out_d;
   logic                data_valid_q, data_valid_d;
   logic                busy_q, busy_d;
   logic [IW-1:0]       win_s;
   logic [IW-1:0]       idx_s;
   logic                win_found_s;
   logic                forced_s;
   logic                release_s;
`ifdef ARBITER_TIMEOUT_EN
   localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
   logic [CW-1:0]       hold_q, hold_d;
   logic                timeout_q, timeout_d;
`endif

   // Round-robin winner: first requester after ptr; lowest offset written last wins.
   always_comb begin
      win_s       = {IW{1'b0}};
      idx_s       = {IW{1'b0}};
      win_found_s = 1'b0;
      for (int k = CHANNELS; k >= 1; k--) begin
         idx_s = IW'((int'(ptr_q) + k) % CHANNELS);
         if (bus.req[idx_s]) begin
            win_s       = idx_s;
            win_found_s = 1'b1;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Release condition: holder dropped its request, or hold limit reached.
   always_comb begin
`ifdef ARBITER_TIMEOUT_EN
      forced_s = bus.req[sel_q] && (hold_q == CW'(MAX_HOLD - 1));
`else
      forced_s = 1'b0;
`endif
      release_s = !bus.req[sel_q] || forced_s;
   end

   // Next-state and next-output computation for the arbitration FSM.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      sel_d        = sel_q;
      ptr_d        = ptr_q;
      data_out_d   = data_out_q;
      data_valid_d = data_valid_q;
      busy_d       = busy_q;
`ifdef ARBITER_TIMEOUT_EN
      hold_d       = hold_q;
      timeout_d    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (win_found_s) begin
               state_d      = S_GRANT;
               sel_d        = win_s;
               busy_d       = 1'b1;
               data_valid_d = 1'b0;
               for (int i = 0; i < CHANNELS; i++) begin
                  grant_d[i] = (win_s == IW'(i));
               end
`ifdef ARBITER_TIMEOUT_EN
               hold_d       = {CW{1'b0}};
`endif
            end else begin
               busy_d = 1'b0;
            end
         end
         S_GRANT: begin
            if (release_s) begin
               // Selector returns to 0 together with grant; ptr remembers the holder.
               state_d      = S_RELEASE;
               grant_d      = {CHANNELS{1'b0}};
               sel_d        = {IW{1'b0}};
               ptr_d        = sel_q;
               data_valid_d = 1'b0;
               busy_d       = 1'b1;
`ifdef ARBITER_TIMEOUT_EN
               timeout_d    = forced_s;
`endif
            end else begin
               data_out_d   = bus.data_in[sel_q*BUS_SIZE +: BUS_SIZE];
               data_valid_d = 1'b1;
`ifdef ARBITER_TIMEOUT_EN
               hold_d       = hold_q + CW'(1);
`endif
            end
         end
         S_RELEASE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d      = S_IDLE;
            grant_d      = {CHANNELS{1'b0}};
            sel_d        = {IW{1'b0}};
            data_valid_d = 1'b0;
            busy_d       = 1'b0;
         end
      endcase
   end

   // State and output registers; reset points ptr at the last channel so channel 0 wins first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         grant_q      <= {CHANNELS{1'b0}};
         sel_q        <= {IW{1'b0}};
         ptr_q        <= IW'(CHANNELS - 1);
         data_out_q   <= {BUS_SIZE{1'b0}};
         data_valid_q <= 1'b0;
         busy_q       <= 1'b0;
`ifdef ARBITER_TIMEOUT_EN
         hold_q       <= {CW{1'b0}};
         timeout_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         sel_q        <= sel_d;
         ptr_q        <= ptr_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         busy_q       <= busy_d;
`ifdef ARBITER_TIMEOUT_EN
         hold_q       <= hold_d;
         timeout_q    <= timeout_d;
`endif
      end
   end

   assign bus.grant      = grant_q;
   assign bus.selector   = CHANNELS'(sel_q);
   assign bus.data_out   = data_out_q;
   assign bus.data_valid = data_valid_q;
   assign bus.busy       = busy_q;
`ifdef ARBITER_TIMEOUT_EN
   assign bus.timeout    = timeout_q;
`else
   assign bus.timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed stimulus with hand-computed expectations plus an
// owner/gap-based reference model compared against the DUT every cycle.
module tb_bus_arbiter;
   localparam int NCH = 4;
   localparam int BW  = 32;
   localparam int MH  = 16;
`ifdef ARBITER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   bit   rand_data = 1'b0;

   bus_arbiter_if #(.CHANNELS(NCH), .BUS_SIZE(BW)) bus ();

   bus_arbiter #(.CHANNELS(NCH), .BUS_SIZE(BW), .MAX_HOLD(MH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // reference model: who owns the bus, whether we are in the 1-cycle release gap
   int          m_owner;
   int          m_ptr;
   int          m_held;
   bit          m_rel;
   bit          m_dv;
   bit          m_to;
   logic [31:0] m_dout;

   function automatic int pick(logic [NCH-1:0] r, int p);
      int ix;
      for (int k = 1; k <= NCH; k++) begin
         ix = (p + k) % NCH;
         if (((r >> ix) & 4'b0001) != 4'b0000) return ix;
      end
      return -1;
   endfunction

   function automatic int idx_of(logic [NCH-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < NCH; i++) begin
         if (((v >> i) & 4'b0001) != 4'b0000) r = i;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // model update on each rising edge, reset asynchronously like the DUT
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_owner <= -1;
         m_rel   <= 1'b0;
         m_ptr   <= NCH - 1;
         m_held  <= 0;
         m_dout  <= 32'h0000_0000;
         m_dv    <= 1'b0;
         m_to    <= 1'b0;
      end else if (m_rel) begin
         m_rel <= 1'b0;
         m_to  <= 1'b0;
      end else if (m_owner < 0) begin
         if (bus.req != 4'b0000) begin
            m_owner <= pick(bus.req, m_ptr);
            m_held  <= 0;
         end
      end else begin
         if (!bus.req[m_owner[1:0]] || (TO_EN && (m_held + 1 == MH))) begin
            m_ptr   <= m_owner;
            m_owner <= -1;
            m_rel   <= 1'b1;
            m_dv    <= 1'b0;
            m_to    <= bus.req[m_owner[1:0]];
         end else begin
            m_dout <= bus.data_in[m_owner*BW +: BW];
            m_dv   <= 1'b1;
            m_held <= m_held + 1;
         end
      end
   end

   // compare DUT outputs with the model on every falling edge
   always @(negedge clk) begin
      check("m_grant",  64'(bus.grant),      64'(m_owner >= 0 ? (1 << m_owner) : 0));
      check("m_sel",    64'(bus.selector),   64'(m_owner >= 0 ? m_owner : 0));
      check("m_busy",   64'(bus.busy),       64'((m_owner >= 0) || m_rel));
      check("m_dv",     64'(bus.data_valid), 64'(m_dv));
      check("m_dout",   64'(bus.data_out),   64'(m_dout));
      check("m_to",     64'(bus.timeout),    64'(m_to));
      check("onehot",   64'($countones(bus.grant) <= 1), 64'(1));
   end

   task automatic tick();
      if (rand_data) begin
         for (int k = 0; k < NCH; k++) bus.data_in[k*BW +: BW] = $urandom;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bus.req = 4'b0000;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      int g;
      int zeros;
      int n;
      bus.req     = 4'b0000;
      bus.data_in = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      reset_n     = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // reset state
      check("rst_grant", 64'(bus.grant),      64'(0));
      check("rst_sel",   64'(bus.selector),   64'(0));
      check("rst_busy",  64'(bus.busy),       64'(0));
      check("rst_dv",    64'(bus.data_valid), 64'(0));
      check("rst_dout",  64'(bus.data_out),   64'(0));
      check("rst_to",    64'(bus.timeout),    64'(0));

      // first request after reset: channel 0 wins, data one cycle later
      bus.req = 4'b0101;
      tick();
      check("lat_grant", 64'(bus.grant),      64'(4'b0001));
      check("lat_sel",   64'(bus.selector),   64'(0));
      check("lat_dv0",   64'(bus.data_valid), 64'(0));
      tick();
      check("lat_dv1",   64'(bus.data_valid), 64'(1));
      check("lat_dout",  64'(bus.data_out),   64'(32'h1111_1111));
      bus.req = 4'b0000;
      tick();
      check("rel_grant", 64'(bus.grant),      64'(0));
      check("rel_busy",  64'(bus.busy),       64'(1));
      check("rel_dv",    64'(bus.data_valid), 64'(0));
      check("rel_hold",  64'(bus.data_out),   64'(32'h1111_1111));
      tick();
      check("idle_busy", 64'(bus.busy),       64'(0));

      // all four requesting, each releasing after 3 grant cycles
      rand_data = 1'b1;
      do_reset();
      bus.req = 4'b1111;
      tick();
      for (int i = 0; i < 5; i++) begin
         zeros = 0;
         while (bus.grant == 4'b0000 && zeros < 10) begin
            zeros++;
            tick();
         end
         if (i > 0) check("rr_gap", 64'(zeros), 64'(2));
         g = idx_of(bus.grant);
         check("rr_order", 64'(g), 64'(i % NCH));
         if (g < 0) g = 0;
         tick();
         tick();
         check("rr_hold", 64'(bus.grant), 64'(1 << g));
         bus.req[g[1:0]] = 1'b0;
         tick();
         bus.req[g[1:0]] = 1'b1;
      end
      bus.req = 4'b0000;
      repeat (3) tick();

      // a new request never preempts the current holder
      do_reset();
      bus.req = 4'b0100;
      tick();
      check("np_grant", 64'(bus.grant),    64'(4'b0100));
      check("np_sel",   64'(bus.selector), 64'(2));
      tick();
      bus.req = 4'b1100;
      repeat (3) begin
         tick();
         check("np_keep", 64'(bus.grant), 64'(4'b0100));
      end
      bus.req = 4'b1000;
      tick();
      check("np_gap1", 64'(bus.grant), 64'(0));
      tick();
      check("np_gap2", 64'(bus.grant), 64'(0));
      tick();
      check("np_next", 64'(bus.grant),    64'(4'b1000));
      check("np_sel3", 64'(bus.selector), 64'(3));
      bus.req = 4'b0000;
      repeat (3) tick();

      // long hold with two requesters
      do_reset();
      bus.req = 4'b0011;
      tick();
      n = 0;
      while (bus.grant == 4'b0001 && n < 40) begin
         n++;
         tick();
      end
`ifdef ARBITER_TIMEOUT_EN
      check("to_len",   64'(n),            64'(16));
      check("to_pulse", 64'(bus.timeout),  64'(1));
      check("to_grant", 64'(bus.grant),    64'(0));
      tick();
      check("to_once",  64'(bus.timeout),  64'(0));
      tick();
      check("to_next",  64'(bus.grant),    64'(4'b0010));
`else
      check("hold_len", 64'(n),            64'(40));
      check("hold_to",  64'(bus.timeout),  64'(0));
      bus.req = 4'b0010;
      tick();
      check("hold_rel", 64'(bus.grant),    64'(0));
      tick();
      tick();
      check("hold_next", 64'(bus.grant),   64'(4'b0010));
`endif
      bus.req = 4'b0000;
      repeat (3) tick();

      // asynchronous reset in the middle of a grant
      do_reset();
      bus.req = 4'b0001;
      tick();
      tick();
      tick();
      check("ar_pre", 64'(bus.data_valid), 64'(1));
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_grant", 64'(bus.grant),      64'(0));
      check("ar_sel",   64'(bus.selector),   64'(0));
      check("ar_dout",  64'(bus.data_out),   64'(0));
      check("ar_dv",    64'(bus.data_valid), 64'(0));
      check("ar_busy",  64'(bus.busy),       64'(0));
      check("ar_to",    64'(bus.timeout),    64'(0));
      tick();
      reset_n = 1'b1;
      bus.req = 4'b1000;
      tick();
      check("ar_grant3", 64'(bus.grant),    64'(4'b1000));
      check("ar_sel3",   64'(bus.selector), 64'(3));
      bus.req = 4'b0000;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
